// File: rtl/maquina_estados_mascota_pkg.sv
// Shared definitions for the pet state machine: state codes, level constants
// and the combinational priority rule that picks the candidate state.
package maquina_estados_mascota_pkg;

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRO     = 3'd1,
    TRISTE     = 3'd2,
    CANSADO    = 3'd3,
    HAMBRIENTO = 3'd4,
    ENFERMO    = 3'd5,
    MUERTO     = 3'd6,
    TEST       = 3'd7
  } estado_t;

  localparam logic [1:0] NIVEL_VACIO = 2'd0;
  localparam logic [1:0] NIVEL_LLENO = 2'd3;

  // Last display index shown in TEST mode before wrapping back to 0
  localparam logic [2:0] ULTIMO_INDICE = 3'd6;

  // Candidate normal state, first match wins: sickness, hunger, tiredness,
  // sadness, then happy only when every need is at least half full
  function automatic estado_t candidato(input logic [1:0] animo,
                                        input logic [1:0] energia,
                                        input logic [1:0] descanso,
                                        input logic [1:0] medicina);
    if (medicina == NIVEL_VACIO)      return ENFERMO;
    else if (energia == NIVEL_VACIO)  return HAMBRIENTO;
    else if (descanso == NIVEL_VACIO) return CANSADO;
    else if (animo == NIVEL_VACIO)    return TRISTE;
    else if (animo >= 2'd2 && energia >= 2'd2 &&
             descanso >= 2'd2 && medicina >= 2'd2) return FELIZ;
    else                              return NEUTRO;
  endfunction

  // Number of needs that are completely empty
  function automatic logic [2:0] cuenta_vacios(input logic [1:0] animo,
                                               input logic [1:0] energia,
                                               input logic [1:0] descanso,
                                               input logic [1:0] medicina);
    return {2'b00, animo == NIVEL_VACIO}    + {2'b00, energia == NIVEL_VACIO} +
           {2'b00, descanso == NIVEL_VACIO} + {2'b00, medicina == NIVEL_VACIO};
  endfunction

endpackage

// File: rtl/maquina_estados_mascota_divisor_segundos.sv
// One-second tick generator: free-running modulo-CYCLES_PER_SEC counter with a
// synchronous clear and a single-cycle tick on the last count.
module divisor_segundos #(
  parameter int CYCLES_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CYCLES_PER_SEC - 1);

  logic [W-1:0] cuenta_reg;

  // Count cycles, restarting on the last count or when cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cuenta_reg <= '0;
    else if (clear || cuenta_reg == ULTIMO)
      cuenta_reg <= '0;
    else
      cuenta_reg <= cuenta_reg + 1'b1;
  end

  // A clear restarts the second, so it also swallows a tick due that cycle
  assign tick = (cuenta_reg == ULTIMO) && !clear;

endmodule

// File: rtl/maquina_estados_mascota.sv
// Pet state machine: turns the four need levels and the test pulse into the
// displayed state, the refill enables, the change pulse and the alert flag.
module maquina_estados_mascota
  import maquina_estados_mascota_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int DEATH_SEC      = 30,
  parameter int TEST_SEC       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       test,
  input  logic [1:0] nivel_animo,
  input  logic [1:0] nivel_energia,
  input  logic [1:0] nivel_descanso,
  input  logic [1:0] nivel_medicina,
  output logic [2:0] estado,
  output logic       activo_comida,
  output logic       activo_medicina,
  output logic       cambio_estado,
  output logic       alerta
);

  localparam int DW = $clog2(DEATH_SEC + 1);
  localparam int TW = $clog2(TEST_SEC + 1);
  localparam logic [DW-1:0] MUERTE_MAX  = DW'(DEATH_SEC);
  localparam logic [TW-1:0] TEST_ULTIMO = TW'(TEST_SEC - 1);

  estado_t       estado_reg, estado_next;
  logic          activo_comida_reg, activo_comida_next;
  logic          activo_medicina_reg, activo_medicina_next;
  logic          cambio_reg, cambio_next;
  logic          alerta_reg, alerta_next;
  logic [DW-1:0] muerte_cnt_reg;
  logic [TW-1:0] test_cnt_reg;
  logic [2:0]    indice_reg;

  estado_t    cand;
  logic [2:0] vacios;
  logic       dos_vacios, algun_vacio;
  logic       es_normal, muerte, entra_test, paso, tick;

  assign cand        = candidato(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
  assign vacios      = cuenta_vacios(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
  assign dos_vacios  = (vacios >= 3'd2);
  assign algun_vacio = (vacios != 3'd0);
  assign es_normal   = (estado_reg != MUERTO) && (estado_reg != TEST);
  // Death takes precedence over a test pulse arriving in the same cycle
  assign muerte      = es_normal && (muerte_cnt_reg == MUERTE_MAX);
  assign entra_test  = es_normal && test && !muerte;
  assign paso        = (estado_reg == TEST) && tick && (test_cnt_reg == TEST_ULTIMO);

  divisor_segundos #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_divisor (
    .clk  (clk),
    .reset(reset),
    .clear(entra_test),
    .tick (tick)
  );

  // State register, with all outputs registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg          <= FELIZ;
      activo_comida_reg   <= 1'b0;
      activo_medicina_reg <= 1'b0;
      cambio_reg          <= 1'b0;
      alerta_reg          <= 1'b0;
    end else begin
      estado_reg          <= estado_next;
      activo_comida_reg   <= activo_comida_next;
      activo_medicina_reg <= activo_medicina_next;
      cambio_reg          <= cambio_next;
      alerta_reg          <= alerta_next;
    end
  end

  // Next state: MUERTO is terminal, TEST waits for a second pulse
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      MUERTO:  estado_next = MUERTO;
      TEST:    if (test) estado_next = cand;
      default: begin
        if (muerte)      estado_next = MUERTO;
        else if (test)   estado_next = TEST;
        else             estado_next = cand;
      end
    endcase
  end

  // Output values that will accompany the next state
  always_comb begin
    activo_comida_next   = 1'b0;
    activo_medicina_next = 1'b0;
    alerta_next          = 1'b0;
    case (estado_next)
      MUERTO: ;
      TEST: begin
        activo_comida_next   = 1'b1;
        activo_medicina_next = 1'b1;
      end
      default: begin
        activo_comida_next   = (nivel_energia <= 2'd1);
        activo_medicina_next = (estado_next == ENFERMO);
        alerta_next          = algun_vacio;
      end
    endcase
    cambio_next = (estado_next != estado_reg) || paso;
  end

  // Death counter: seconds spent with two or more empty needs, normal states only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      muerte_cnt_reg <= '0;
    else if (!es_normal || entra_test || !dos_vacios)
      muerte_cnt_reg <= '0;
    else if (tick && muerte_cnt_reg != MUERTE_MAX)
      muerte_cnt_reg <= muerte_cnt_reg + 1'b1;
  end

  // TEST display stepping: advance the index every TEST_SEC seconds, wrap 6 -> 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_cnt_reg <= '0;
      indice_reg   <= 3'd0;
    end else if (estado_reg != TEST) begin
      test_cnt_reg <= '0;
      indice_reg   <= 3'd0;
    end else if (tick) begin
      if (test_cnt_reg == TEST_ULTIMO) begin
        test_cnt_reg <= '0;
        indice_reg   <= (indice_reg == ULTIMO_INDICE) ? 3'd0 : indice_reg + 3'd1;
      end else begin
        test_cnt_reg <= test_cnt_reg + 1'b1;
      end
    end
  end

  assign estado          = estado_reg;
  assign activo_comida   = activo_comida_reg;
  assign activo_medicina = activo_medicina_reg;
  assign cambio_estado   = cambio_reg;
  assign alerta          = alerta_reg;

endmodule

// File: tb/tb_maquina_estados_mascota.sv
// Directed bench for the pet state machine with a short second (10 clk),
// a 3 s death threshold and 2 s per TEST display step.
module tb_maquina_estados_mascota;

  logic       clk = 1'b0;
  logic       reset;
  logic       test;
  logic [1:0] nivel_animo, nivel_energia, nivel_descanso, nivel_medicina;
  logic [2:0] estado;
  logic       activo_comida, activo_medicina, cambio_estado, alerta;

  int total = 0;
  int bad   = 0;

  maquina_estados_mascota #(
    .CYCLES_PER_SEC(10),
    .DEATH_SEC     (3),
    .TEST_SEC      (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .test           (test),
    .nivel_animo    (nivel_animo),
    .nivel_energia  (nivel_energia),
    .nivel_descanso (nivel_descanso),
    .nivel_medicina (nivel_medicina),
    .estado         (estado),
    .activo_comida  (activo_comida),
    .activo_medicina(activo_medicina),
    .cambio_estado  (cambio_estado),
    .alerta         (alerta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] an, en, de, me;
    logic       tp;
    logic [2:0] e;
    logic       c, m, ch, al;
  } vec_t;

  vec_t tabla[14];

  function automatic vec_t mk(input logic [1:0] an, input logic [1:0] en,
                              input logic [1:0] de, input logic [1:0] me,
                              input logic tp, input logic [2:0] e,
                              input logic c, input logic m,
                              input logic ch, input logic al);
    vec_t v;
    v.an = an; v.en = en; v.de = de; v.me = me; v.tp = tp;
    v.e = e; v.c = c; v.m = m; v.ch = ch; v.al = al;
    return v;
  endfunction

  task automatic chk(input string nombre, input int actual, input int esperado);
    total++;
    if (actual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, esperado, $time);
    end
  endtask

  task automatic esperar(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic niveles(input logic [1:0] an, input logic [1:0] en,
                         input logic [1:0] de, input logic [1:0] me);
    nivel_animo = an; nivel_energia = en; nivel_descanso = de; nivel_medicina = me;
  endtask

  // Holds reset over two edges and releases it 1 time unit after an edge
  task automatic do_reset();
    reset = 1'b1;
    test  = 1'b0;
    niveles(2'd3, 2'd3, 2'd3, 2'd3);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int npulsos, nfuera, nno7;

    // Vectors applied one per clock from reset, each checked after the edge
    tabla[0]  = mk(2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[1]  = mk(2'd3, 2'd1, 2'd3, 2'd3, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tabla[2]  = mk(2'd3, 2'd1, 2'd3, 2'd3, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tabla[3]  = mk(2'd3, 2'd0, 2'd3, 2'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    tabla[4]  = mk(2'd0, 2'd3, 2'd3, 2'd3, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    tabla[5]  = mk(2'd3, 2'd3, 2'd0, 2'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tabla[6]  = mk(2'd3, 2'd0, 2'd3, 2'd3, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tabla[7]  = mk(2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tabla[8]  = mk(2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tabla[9]  = mk(2'd1, 2'd2, 2'd3, 2'd3, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tabla[10] = mk(2'd2, 2'd3, 2'd2, 2'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[11] = mk(2'd3, 2'd0, 2'd3, 2'd3, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tabla[12] = mk(2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tabla[13] = mk(2'd3, 2'd0, 2'd3, 2'd3, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset state
    do_reset();
    chk("reset_estado", estado, 0);
    chk("reset_comida", activo_comida, 0);
    chk("reset_medicina", activo_medicina, 0);
    chk("reset_cambio", cambio_estado, 0);
    chk("reset_alerta", alerta, 0);

    // Priority, enables, change pulse, TEST entry/exit via the table
    for (int i = 0; i < 14; i++) begin
      niveles(tabla[i].an, tabla[i].en, tabla[i].de, tabla[i].me);
      test = tabla[i].tp;
      esperar(1);
      test = 1'b0;
      chk($sformatf("v%0d_estado", i), estado, tabla[i].e);
      chk($sformatf("v%0d_comida", i), activo_comida, tabla[i].c);
      chk($sformatf("v%0d_medicina", i), activo_medicina, tabla[i].m);
      chk($sformatf("v%0d_cambio", i), cambio_estado, tabla[i].ch);
      chk($sformatf("v%0d_alerta", i), alerta, tabla[i].al);
      $display("vector %0d: estado=%0d comida=%0b medicina=%0b cambio=%0b alerta=%0b",
               i, estado, activo_comida, activo_medicina, cambio_estado, alerta);
    end

    // Death: ticks land on edges 10, 20, 30 after reset release; MUERTO at 31.
    // The test pulse on the threshold cycle must lose to death.
    do_reset();
    niveles(2'd0, 2'd3, 2'd0, 2'd3);
    esperar(30);
    chk("muerte_antes", estado, 3);
    test = 1'b1;
    esperar(1);
    test = 1'b0;
    chk("muerte_estado", estado, 6);
    chk("muerte_comida", activo_comida, 0);
    chk("muerte_medicina", activo_medicina, 0);
    chk("muerte_alerta", alerta, 0);
    chk("muerte_cambio", cambio_estado, 1);
    niveles(2'd3, 2'd3, 2'd3, 2'd3);
    esperar(2);
    test = 1'b1;
    esperar(1);
    test = 1'b0;
    esperar(3);
    chk("muerte_pegajosa", estado, 6);
    chk("muerte_pegajosa_cambio", cambio_estado, 0);
    $display("death sequence: estado=%0d", estado);

    // Death counter cleared by a restored level; a fresh three seconds needed
    do_reset();
    niveles(2'd0, 2'd3, 2'd0, 2'd3);
    esperar(25);
    nivel_descanso = 2'd3;
    esperar(2);
    chk("recupera_estado", estado, 2);
    nivel_descanso = 2'd0;
    esperar(4);
    chk("recupera_sin_muerte", estado, 3);
    esperar(19);
    chk("recupera_antes", estado, 3);
    esperar(1);
    chk("recupera_muerte", estado, 6);
    $display("death clear sequence: estado=%0d", estado);

    // TEST stepping: pulses at 20, 40, ..., 140 clk after entry
    do_reset();
    esperar(3);
    test = 1'b1;
    esperar(1);
    test = 1'b0;
    chk("test_estado", estado, 7);
    chk("test_comida", activo_comida, 1);
    chk("test_medicina", activo_medicina, 1);
    chk("test_cambio_entrada", cambio_estado, 1);
    npulsos = 0; nfuera = 0; nno7 = 0;
    for (int i = 1; i <= 140; i++) begin
      esperar(1);
      if (estado != 3'd7) nno7++;
      if (cambio_estado) begin
        npulsos++;
        if (i % 20 != 0) nfuera++;
      end
    end
    chk("test_pasos", npulsos, 7);
    chk("test_pasos_fuera", nfuera, 0);
    chk("test_estado_fijo", nno7, 0);
    nivel_energia = 2'd0;
    test = 1'b1;
    esperar(1);
    test = 1'b0;
    chk("test_salida_estado", estado, 4);
    chk("test_salida_comida", activo_comida, 1);
    chk("test_salida_medicina", activo_medicina, 0);
    chk("test_salida_alerta", alerta, 1);
    chk("test_salida_cambio", cambio_estado, 1);
    $display("test mode sequence: pulses=%0d exit estado=%0d", npulsos, estado);

    // Asynchronous reset between edges while in TEST
    do_reset();
    esperar(2);
    test = 1'b1;
    esperar(1);
    test = 1'b0;
    esperar(5);
    chk("async_pre_estado", estado, 7);
    #2 reset = 1'b1;
    #1;
    chk("async_estado", estado, 0);
    chk("async_comida", activo_comida, 0);
    chk("async_medicina", activo_medicina, 0);
    chk("async_cambio", cambio_estado, 0);
    chk("async_alerta", alerta, 0);
    $display("async reset: estado=%0d comida=%0b medicina=%0b", estado, activo_comida, activo_medicina);
    esperar(1);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
